// File: rtl/ps2_rx_frame_pkg.sv
// Shared PS/2 receive definitions: FSM states, frame geometry, break code and parity helper.
package ps2_rx_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    STOP = 2'd2,
    LOAD = 2'd3
  } state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;
  localparam logic [PS2_DATA_BITS-1:0] PS2_BREAK = 8'hF0;

  // Odd parity over data plus parity bit: the XOR of all nine bits must be 1.
  function automatic logic parity_ok(input logic [PS2_DATA_BITS:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx_frame_clk_filter.sv
// Synchronises the raw PS/2 lines, debounces ps2c and emits a one-cycle falling-edge strobe.
module ps2_rx_frame_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall,
  output logic d_sync
);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync_r;
  logic [FILTER_LEN-1:0] filt;
  logic                  f_clk;
  logic                  f_clk_q;

  // f_clk only moves once the whole history agrees, so shorter glitches leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync   <= '1;
      d_sync_r <= '1;
      filt     <= '1;
      f_clk    <= 1'b1;
      f_clk_q  <= 1'b1;
    end else begin
      c_sync   <= {c_sync[0], ps2c};
      d_sync_r <= {d_sync_r[0], ps2d};
      filt     <= {filt[FILTER_LEN-2:0], c_sync[1]};
      if (&filt)
        f_clk <= 1'b1;
      else if (~|filt)
        f_clk <= 1'b0;
      f_clk_q  <= f_clk;
    end
  end

  assign fall   = f_clk_q & ~f_clk;
  assign d_sync = d_sync_r[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: deframes start/8 data/odd parity/stop and flags bad frames.
module ps2_rx_frame
  import ps2_rx_frame_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_en,
  input  logic                     ps2c,
  input  logic                     ps2d,
  output logic [PS2_DATA_BITS-1:0] dout,
  output logic                     ready,
  output logic                     parity_err,
  output logic                     frame_err
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    N_BITS   = 4'(PS2_FRAME_BITS - 2);

  state_t                   state, state_d;
  logic [3:0]               n, n_d;
  logic [PS2_DATA_BITS:0]   sh, sh_d;
  logic                     stop, stop_d;
  logic [TW-1:0]            tmo, tmo_d;
  logic [PS2_DATA_BITS-1:0] dout_d;
  logic                     ready_d, perr_d, ferr_d;
  logic                     fall, d_s;
  logic                     tmo_hit;

  ps2_rx_frame_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk    (clk),
    .reset  (reset),
    .ps2c   (ps2c),
    .ps2d   (ps2d),
    .fall   (fall),
    .d_sync (d_s)
  );

  assign tmo_hit = ((state == DPS) || (state == STOP)) && (tmo == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      n          <= '0;
      sh         <= '0;
      stop       <= 1'b0;
      tmo        <= '0;
      dout       <= '0;
      ready      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      n          <= n_d;
      sh         <= sh_d;
      stop       <= stop_d;
      tmo        <= tmo_d;
      dout       <= dout_d;
      ready      <= ready_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
    end
  end

  // Timeout is tested before fall so an edge coinciding with expiry is dropped, not taken as a start bit.
  always_comb begin
    state_d = state;
    n_d     = n;
    sh_d    = sh;
    stop_d  = stop;
    tmo_d   = tmo;
    dout_d  = dout;
    ready_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state)
      IDLE: begin
        tmo_d = '0;
        if (fall && rx_en && !d_s) begin
          state_d = DPS;
          n_d     = N_BITS;
        end
      end
      DPS: begin
        if (tmo_hit) begin
          ferr_d  = 1'b1;
          sh_d    = '0;
          state_d = IDLE;
        end else if (fall) begin
          sh_d  = {d_s, sh[PS2_DATA_BITS:1]};
          n_d   = n - 4'd1;
          tmo_d = '0;
          if (n == 4'd1)
            state_d = STOP;
        end else begin
          tmo_d = tmo + TW'(1);
        end
      end
      STOP: begin
        if (tmo_hit) begin
          ferr_d  = 1'b1;
          sh_d    = '0;
          state_d = IDLE;
        end else if (fall) begin
          stop_d  = d_s;
          tmo_d   = '0;
          state_d = LOAD;
        end else begin
          tmo_d = tmo + TW'(1);
        end
      end
      LOAD: begin
        state_d = IDLE;
        if (parity_ok(sh) && stop) begin
          dout_d  = sh[PS2_DATA_BITS-1:0];
          ready_d = 1'b1;
        end
        perr_d = ~parity_ok(sh);
        ferr_d = ~stop;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: randomized PS/2 frames against a frame-level reference model.
module tb_ps2_rx_frame;
  import ps2_rx_frame_pkg::*;

  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_en = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] dout;
  logic       ready, parity_err, frame_err;

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_en      (rx_en),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .dout       (dout),
    .ready      (ready),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit         rdy;
    bit         perr;
    bit         ferr;
    logic [7:0] d;
    bit         timed;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] model_dout = 8'h00;
  int         last_fall_cyc = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data changes mid-way through ps2c high, optional short glitch, then a low half-period.
  task automatic ps2_bit(input bit b, input bit glitch);
    tick(8);
    ps2d = b;
    if (glitch) begin
      ps2c = 1'b0;
      tick(FL - 2);
      ps2c = 1'b1;
    end
    tick(HALF);
    ps2c = 1'b0;
    last_fall_cyc = cyc;
    tick(HALF);
    ps2c = 1'b1;
  endtask

  // Reference model: a frame is good iff data+parity has an odd number of ones and stop is 1.
  function automatic void expect_frame(input logic [7:0] d, input bit pbit, input bit stopb);
    exp_t e;
    bit   good_par;
    good_par = (($countones(d) + int'(pbit)) % 2) == 1;
    e.rdy   = good_par && stopb;
    e.perr  = !good_par;
    e.ferr  = !stopb;
    if (e.rdy) model_dout = d;
    e.d     = model_dout;
    e.timed = 1'b0;
    exp_q.push_back(e);
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stopb,
                            input int glitch_at, input int drop_en_at);
    bit pbit;
    bit b;
    pbit = (($countones(d) % 2) == 0) ^ pflip;
    if (rx_en) expect_frame(d, pbit, stopb);
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      b = 1'b0;
      else if (i <= 8) b = d[i-1];
      else if (i == 9) b = pbit;
      else             b = stopb;
      if (i == drop_en_at) rx_en = 1'b0;
      ps2_bit(b, i == glitch_at);
    end
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i], 1'b0);
  endtask

  // Monitor: every output pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    int   dly;
    if (reset && (ready || parity_err || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, ready, parity_err, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("flags", {29'd0, ready, parity_err, frame_err}, {29'd0, e.rdy, e.perr, e.ferr});
        check("dout", {24'd0, dout}, {24'd0, e.d});
        if (e.timed) begin
          dly = cyc - last_fall_cyc;
          n_chk++;
          if (dly < TO + FL + 3 || dly > TO + FL + 5) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d", dly, TO + FL + 3, TO + FL + 5);
          end
        end
      end
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t  et;
    int    kind;
    int    gl;
    logic [7:0] rd;

    tick(4);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_flags", {29'd0, ready, parity_err, frame_err}, 32'd0);
    reset = 1'b1;
    rx_en = 1'b1;
    tick(20);

    send_frame(8'h1C, 1'b0, 1'b1, -1, -1);
    send_frame(PS2_BREAK, 1'b0, 1'b1, -1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1, -1);
    send_frame(8'h1C, 1'b1, 1'b1, -1, -1);
    send_frame(8'h1C, 1'b0, 1'b0, -1, -1);
    send_frame(8'h1C, 1'b1, 1'b0, -1, -1);

    // Glitches in IDLE and mid-frame must not consume a bit.
    tick(10);
    ps2c = 1'b0;
    tick(FL - 2);
    ps2c = 1'b1;
    tick(20);
    send_frame(8'h5A, 1'b0, 1'b1, 4, -1);

    // Abandoned frame: frame_err after the inter-edge timeout, then recovery.
    send_partial(8'h3C, 4);
    et.rdy = 1'b0; et.perr = 1'b0; et.ferr = 1'b1; et.d = model_dout; et.timed = 1'b1;
    exp_q.push_back(et);
    tick(TO + FL + 40);
    check("timeout_seen", exp_q.size(), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, -1, -1);

    // Asynchronous reset mid-frame clears outputs at once and returns to IDLE.
    send_partial(8'hA5, 3);
    reset = 1'b0;
    #1;
    check("midrst_dout", {24'd0, dout}, 32'd0);
    check("midrst_flags", {29'd0, ready, parity_err, frame_err}, 32'd0);
    model_dout = 8'h00;
    tick(3);
    reset = 1'b1;
    tick(20);
    send_frame(8'h5A, 1'b0, 1'b1, -1, -1);

    // rx_en low at the start bit ignores the frame; dropping it later does not.
    rx_en = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, -1, -1);
    rx_en = 1'b1;
    send_frame(8'h77, 1'b0, 1'b1, -1, 3);
    rx_en = 1'b1;

    for (int k = 0; k < 24; k++) begin
      rd   = 8'($urandom);
      kind = $urandom_range(0, 5);
      gl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : -1;
      send_frame(rd, kind == 0 || kind == 2, !(kind == 1 || kind == 2), gl, -1);
    end

    tick(200);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_dout", {24'd0, dout}, {24'd0, model_dout});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
